axis_fringe_generator: RTL and testbench
========================================

# axis_fringe_generator

Synthesises a quadrature fringe stream (signal_a / signal_b square waves) that walks from its current position to a commanded target position at a programmable rate. It is the transmit-side counterpart of the fringe-counting position tracker: its M_AXIS output, packed as {signal_b, signal_a}, is fed to the tracker input so the tracker reproduces the commanded position. It is used for closed-loop self-test and for driving the DAC path with synthetic interferometer signals.

## Interface
- S_AXIS_TDATA_WIDTH, 16: signed target position, in fringes.
- M_AXIS_TDATA_WIDTH, 32: packed output sample; the low half is signal_a and the high half is signal_b, both signed.
- aclk  in  1  clock.
- aresetn  in  1  reset, synchronous, active-low.
- amplitude  in  15  unsigned fringe amplitude; sampled on target acceptance.
- dwell  in  16  handshakes per quarter-fringe step; sampled on target acceptance; 0 is treated as 1.
- S_AXIS_tvalid  in  1  target valid.
- S_AXIS_tdata  in  S_AXIS_TDATA_WIDTH  signed target position.
- S_AXIS_tready  out  1  high only in IDLE.
- M_AXIS_tready  in  1  downstream ready.
- M_AXIS_tvalid  out  1  sample valid.
- M_AXIS_tdata  out  M_AXIS_TDATA_WIDTH  {signal_b, signal_a}.
- busy  out  1  high in MOVE.

## Operation
- **Internal position:** q is a signed quarter-fringe accumulator, S_AXIS_TDATA_WIDTH+2 bits wide. phase = q[1:0]. position = q >>> 2.
- **Phase-to-sample mapping:**
  - signal_a = +amp when phase is 1 or 2, otherwise -amp.
  - signal_b = +amp when phase is 2 or 3, otherwise -amp.
  - Values are sign-extended to half of M_AXIS_TDATA_WIDTH.
  - Forward sequence 0→1→2→3→0: signal_a falls while signal_b is high, so the tracker counts +1.
  - Reverse sequence: signal_a falls while signal_b is low, so the tracker counts -1.
- **States:**
  - IDLE:
    - q equals target_q. S_AXIS_tready = 1.
    - On S handshake: target_q = {tdata, 2'b00}; amp and dwell are latched; dwell_cnt = 0.
    - If target_q equals q, stay in IDLE. Otherwise go to MOVE.
  - MOVE:
    - S_AXIS_tready = 0.
    - Each M handshake (tvalid & tready) increments dwell_cnt.
    - When a handshake occurs with dwell_cnt == dwell_l-1: q steps by +1 if target_q > q, else by -1, and dwell_cnt = 0.
    - If the stepped q equals target_q, go to IDLE.
- **Flow control:** M_AXIS_tready low stalls both dwell_cnt and q, and holds tdata stable. Stepping never occurs without a handshake.
- **Arithmetic:**
  - All comparisons on q and target_q are signed, at full S_AXIS_TDATA_WIDTH+2 width.
  - q cannot overflow, because target_q is bounded by the input width.
  - amp is at most 32767, so -amp is always representable.
- **Reset mid-MOVE:** q, target_q and dwell_cnt clear, and the state returns to IDLE. The tracker must be reset alongside for consistent positions.
- A new target can only be accepted in IDLE. There is no retargeting during MOVE.

## Timing
- **Reset values:**
  - M_AXIS_tvalid = 0, becoming 1 in the first cycle after aresetn goes high.
  - M_AXIS_tdata = 0.
  - S_AXIS_tready = 1, busy = 0, q = 0, amp = 0, dwell_l = 1.
- **Target acceptance:** an S handshake in cycle T gives busy = 1 in cycle T+1.
- **Sample latency:** M_AXIS_tdata is registered. It reflects the new q one cycle after the step handshake.
- **Step rate:** with tready held high, one quarter step occurs every dwell_l cycles. A move of N fringes takes 4·|N|·dwell_l handshakes.
- **Return to IDLE:** S_AXIS_tready reasserts in the cycle after the final step.

## Structure
- Shared package axis_fringe_pkg holds:
  - state encoding: IDLE = 1'b0, MOVE = 1'b1;
  - phase constants;
  - the quadrature mapping function (phase → {b_pos, a_pos}).
- Sub-module fringe_dwell_timer: the dwell counter with enable and terminal-count pulse. It is instantiated once.

## Test plan
- **Reset:** hold aresetn low for 3 cycles → M_AXIS_tvalid = 0, S_AXIS_tready = 1, tdata = 0. After release: tvalid = 1, tdata = {-amp, -amp} with amp = 0, i.e. 0.
- **Forward move:** amplitude = 1000, dwell = 2, target = +3, tready held high → 12 steps over 24 handshakes. The phase sequence in signal_a/signal_b is 1,2,3,0 repeated. Chained tracker (thresholds ±500, log_scale = 0) ends at position 3.
- **Reverse move:** from +3, target = -2 → 20 steps. Tracker ends at -2. Each fringe falls with signal_b = -1000.
- **Backpressure:** dwell = 4, tready toggled 1,0,0,1 → tdata stable while tready is low. The step count equals handshakes/4 exactly.
- **Boundary values:**
  - target equal to the current position → no MOVE, busy stays 0.
  - dwell = 0 → a step on every handshake.
  - target = -32768 → the move completes with no wrap.
- **Reset mid-MOVE:** reset asserted at step 5 of 12 → q = 0, IDLE, tready = 1. A new target is accepted on the next cycle.

Source files
------------

// File: rtl/axis_fringe_generator_pkg.sv
// axis_fringe_pkg: state encoding, phase constants and quadrature mapping for the fringe generator
package axis_fringe_pkg;
    typedef enum logic {IDLE = 1'b0, MOVE = 1'b1} state_t;
    localparam logic [1:0] PH0 = 2'd0;
    localparam logic [1:0] PH1 = 2'd1;
    localparam logic [1:0] PH2 = 2'd2;
    localparam logic [1:0] PH3 = 2'd3;
    function automatic logic [1:0] quad_map(input logic [1:0] ph);
        return {ph == PH2 || ph == PH3, ph == PH1 || ph == PH2};
    endfunction
endpackage

// File: rtl/axis_fringe_generator_dwell_timer.sv
// fringe_dwell_timer: counts enabled handshakes and pulses on the last one of each dwell period
module fringe_dwell_timer (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        clr,
    input  logic        en,
    input  logic [15:0] dwell_l,
    output logic        tick
);
    logic [15:0] cnt;
    assign tick = en && cnt == dwell_l - 16'd1;
    always_ff @(posedge aclk) begin
        if (!aresetn || clr)
            cnt <= '0;
        else if (en)
            cnt <= tick ? '0 : cnt + 16'd1;
    end
endmodule

// File: rtl/axis_fringe_generator.sv
// axis_fringe_generator: walks a quadrature square-wave stream from its position to a commanded target
module axis_fringe_generator
    import axis_fringe_pkg::*;
#(
    parameter int S_AXIS_TDATA_WIDTH = 16,
    parameter int M_AXIS_TDATA_WIDTH = 32
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [14:0]                   amplitude,
    input  logic [15:0]                   dwell,
    input  logic                          S_AXIS_tvalid,
    input  logic [S_AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
    output logic                          S_AXIS_tready,
    input  logic                          M_AXIS_tready,
    output logic                          M_AXIS_tvalid,
    output logic [M_AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
    output logic                          busy
);
    localparam int QW = S_AXIS_TDATA_WIDTH + 2;
    localparam int HW = M_AXIS_TDATA_WIDTH / 2;
    state_t                state;
    logic signed [QW-1:0]  q, target_q, s_target, q_step, q_next;
    logic [14:0]           amp, amp_next;
    logic [15:0]           dwell_l;
    logic                  s_hs, m_hs, tick;
    logic [1:0]            pos;
    logic signed [HW-1:0]  amp_p, amp_n;

    assign S_AXIS_tready = state == IDLE;
    assign busy          = state == MOVE;
    assign s_hs          = S_AXIS_tvalid && state == IDLE;
    assign m_hs          = M_AXIS_tvalid && M_AXIS_tready && state == MOVE;
    assign s_target      = {S_AXIS_tdata, 2'b00};
    assign q_step        = (target_q > q) ? q + QW'(1) : q - QW'(1);
    assign q_next        = tick ? q_step : q;
    assign amp_next      = s_hs ? amplitude : amp;
    // Output sample is built from next-state values so it tracks q one cycle after the step handshake.
    assign pos           = quad_map(q_next[1:0]);
    assign amp_p         = HW'(amp_next);
    assign amp_n         = -amp_p;

    fringe_dwell_timer u_timer (
        .aclk    (aclk),
        .aresetn (aresetn),
        .clr     (s_hs),
        .en      (m_hs),
        .dwell_l (dwell_l),
        .tick    (tick)
    );

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state         <= IDLE;
            q             <= '0;
            target_q      <= '0;
            amp           <= '0;
            dwell_l       <= 16'd1;
            M_AXIS_tvalid <= 1'b0;
            M_AXIS_tdata  <= '0;
        end else begin
            M_AXIS_tvalid <= 1'b1;
            M_AXIS_tdata  <= {pos[1] ? amp_p : amp_n, pos[0] ? amp_p : amp_n};
            q             <= q_next;
            amp           <= amp_next;
            if (s_hs) begin
                target_q <= s_target;
                dwell_l  <= (dwell == 16'd0) ? 16'd1 : dwell;
                state    <= (s_target == q) ? IDLE : MOVE;
            end else if (tick && q_step == target_q) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_axis_fringe_generator.sv
// tb_axis_fringe_generator: table, hand-written and random moves checked against a fringe-level model
module tb_axis_fringe_generator;
    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [14:0] amplitude = '0;
    logic [15:0] dwell = '0;
    logic        S_AXIS_tvalid = 1'b0;
    logic [15:0] S_AXIS_tdata = '0;
    logic        S_AXIS_tready;
    logic        M_AXIS_tready = 1'b0;
    logic        M_AXIS_tvalid;
    logic [31:0] M_AXIS_tdata;
    logic        busy;

    int n_chk = 0;
    int n_bad = 0;
    int qm = 0;
    int trk = 0;
    bit a_hi = 0;

    typedef struct {
        int tgt;
        int dw;
        int am;
        int mode;
        int exp_hs;
        int exp_pos;
    } vec_t;
    vec_t tbl[5];

    axis_fringe_generator dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .amplitude     (amplitude),
        .dwell         (dwell),
        .S_AXIS_tvalid (S_AXIS_tvalid),
        .S_AXIS_tdata  (S_AXIS_tdata),
        .S_AXIS_tready (S_AXIS_tready),
        .M_AXIS_tready (M_AXIS_tready),
        .M_AXIS_tvalid (M_AXIS_tvalid),
        .M_AXIS_tdata  (M_AXIS_tdata),
        .busy          (busy)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_sample(input int qq, input int am);
        int ph, a, b;
        ph = qq & 3;
        a  = (ph == 1 || ph == 2) ? am : -am;
        b  = (ph >= 2) ? am : -am;
        return {b[15:0], a[15:0]};
    endfunction

    function automatic logic pick(input int mode, input int cyc);
        logic [3:0] pat;
        pat = 4'b1001;
        return mode == 0 ? 1'b1 : mode == 1 ? pat[cyc % 4] : 1'($urandom_range(0, 1));
    endfunction

    // Downstream fringe tracker with +/-500 hysteresis: counts signal_a falls, direction from signal_b.
    task automatic track();
        int a, b;
        if (M_AXIS_tvalid !== 1'b1) return;
        a = int'($signed(M_AXIS_tdata[15:0]));
        b = int'($signed(M_AXIS_tdata[31:16]));
        if (a > 500)
            a_hi = 1;
        else if (a < -500 && a_hi) begin
            a_hi = 0;
            trk += (b > 0) ? 1 : -1;
        end
    endtask

    // Caller is at a negedge in IDLE; returns at the negedge where the move ended or stop_at was hit.
    task automatic move(input int tgt, input int dw, input int am, input int mode,
                        input int stop_at, output int hs);
        int dl, q0, qt, dir, total, k, cyc;
        bit done;
        dl    = dw == 0 ? 1 : dw;
        q0    = qm;
        qt    = tgt * 4;
        dir   = qt > q0 ? 1 : -1;
        total = (qt > q0 ? qt - q0 : q0 - qt) * dl;
        k     = 0;
        cyc   = 0;
        done  = 0;
        chk("s_ready_start", S_AXIS_tready, 1);
        S_AXIS_tvalid = 1'b1;
        S_AXIS_tdata  = 16'(tgt);
        amplitude     = 15'(am);
        dwell         = 16'(dw);
        M_AXIS_tready = 1'b1;
        @(negedge aclk);
        S_AXIS_tvalid = 1'b0;
        while (!done) begin
            track();
            chk("busy", busy, k < total);
            chk("tdata", M_AXIS_tdata, exp_sample(q0 + dir * (k / dl), am));
            if (k == total) chk("s_ready_end", S_AXIS_tready, 1);
            if (k == total || k == stop_at) done = 1;
            else if (cyc > total * 4 + 60) begin
                n_chk++;
                n_bad++;
                $display("FAIL move_timeout: got %0d handshakes want %0d", k, total);
                done = 1;
            end else begin
                M_AXIS_tready = pick(mode, cyc);
                if (M_AXIS_tready) k++;
                cyc++;
                @(negedge aclk);
            end
        end
        qm = q0 + dir * (k / dl);
        hs = k;
    endtask

    task automatic do_reset(input int cycles);
        aresetn = 1'b0;
        repeat (cycles) @(negedge aclk);
        chk("rst_tvalid", M_AXIS_tvalid, 0);
        chk("rst_s_ready", S_AXIS_tready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_tdata", M_AXIS_tdata, 0);
        aresetn = 1'b1;
        qm   = 0;
        trk  = 0;
        a_hi = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs, tgt;
        tbl[0] = '{3, 2, 1000, 0, 24, 3};
        tbl[1] = '{-2, 2, 1000, 0, 40, -2};
        tbl[2] = '{-2, 5, 1000, 0, 0, -2};
        tbl[3] = '{0, 0, 1000, 0, 8, 0};
        tbl[4] = '{1, 4, 2000, 1, 16, 1};

        @(negedge aclk);
        do_reset(2);
        @(negedge aclk);
        chk("post_rst_tvalid", M_AXIS_tvalid, 1);
        chk("post_rst_tdata", M_AXIS_tdata, 0);

        for (int i = 0; i < 5; i++) begin
            move(tbl[i].tgt, tbl[i].dw, tbl[i].am, tbl[i].mode, -1, hs);
            chk("tbl_handshakes", hs, tbl[i].exp_hs);
            chk("tbl_tracker", trk, tbl[i].exp_pos);
        end

        do_reset(2);
        move(3, 1, 1000, 0, -1, hs);
        move(0, 1, 1000, 0, 5, hs);
        chk("mid_handshakes", hs, 5);
        do_reset(1);
        move(1, 1, 1000, 0, -1, hs);
        chk("after_rst_handshakes", hs, 4);
        chk("after_rst_tracker", trk, 1);

        move(-32768, 1, 30000, 2, 40, hs);
        chk("min_target_handshakes", hs, 40);
        chk("min_target_tracker", trk, -9);
        do_reset(2);

        for (int i = 0; i < 12; i++) begin
            tgt = $urandom_range(0, 12) - 6;
            move(tgt, $urandom_range(0, 3), $urandom_range(600, 32767), 2, -1, hs);
            chk("rand_tracker", trk, tgt);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
